// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit back end.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int FRAME_BITS      = 8;
  localparam int DEFAULT_CLK_DIV = 16;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side bundle of the transmit FIFO: byte strobe in, occupancy status out.
interface uart_tx_fifo_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  // wr_en is a one-cycle strobe with no backpressure: the byte is taken on any
  // edge where wr_en=1 and the registered full=0, otherwise dropped and flagged
  // in the sticky overflow bit.
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [LW-1:0]     level;
  logic              overflow;

  modport master (
    output wr_en, wr_data,
    input  full, empty, level, overflow
  );

  modport slave (
    input  wr_en, wr_data,
    output full, empty, level, overflow
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered level/full/empty and a sticky overflow flag.
module sync_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rd_en,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LW-1:0]     level_d;
  logic              wr_acc;
  logic              rd_acc;

  // Decisions use the registered flags, so a same-cycle pop never frees room
  // for a write that arrives while full.
  assign wr_acc  = wr_en && !full;
  assign rd_acc  = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_d = level;
    case ({wr_acc, rd_acc})
      2'b10:   level_d = level + 1'b1;
      2'b01:   level_d = level - 1'b1;
      default: level_d = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      level <= level_d;
      full  <= (level_d == LW'(DEPTH));
      empty <= (level_d == '0);
      if (wr_en && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small FIFO; tx is driven straight from a flop.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV,
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  uart_tx_fifo_if.slave   wr,
  output logic            tx,
  output logic            busy,
  output uart_state_e     fsm_state
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(FRAME_BITS);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(FRAME_BITS - 1);

  uart_state_e       state, state_d;
  logic [CW-1:0]     baud, baud_d;
  logic [BW-1:0]     bit_idx, bit_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic              tx_q, tx_d;
  logic              pop;
  logic              can_start;
  logic              baud_end;

  logic [DATA_W-1:0]        fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     fifo_overflow;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr.wr_en),
    .wr_data  (wr.wr_data),
    .rd_en    (pop),
    .rd_data  (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level),
    .overflow (fifo_overflow)
  );

  assign wr.full     = fifo_full;
  assign wr.empty    = fifo_empty;
  assign wr.level    = fifo_level;
  assign wr.overflow = fifo_overflow;

  assign can_start = ena && !fifo_empty;
  assign baud_end  = (baud == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx_q    <= 1'b1;
    end else begin
      state   <= state_d;
      baud    <= baud_d;
      bit_idx <= bit_d;
      shift   <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // tx_d is the line level for the state being entered, so the pin changes on
  // the same edge as the state register.
  always_comb begin
    state_d = state;
    baud_d  = baud;
    bit_d   = bit_idx;
    shift_d = shift;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (can_start) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          bit_d   = '0;
          baud_d  = BAUD_LOAD;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = BAUD_LOAD;
          state_d = DATA;
          tx_d    = shift[0];
        end else begin
          baud_d = baud - 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = BAUD_LOAD;
          if (bit_idx == LAST_BIT) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            shift_d = shift >> 1;
            bit_d   = bit_idx + 1'b1;
            tx_d    = shift_d[0];
          end
        end else begin
          baud_d = baud - 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          if (can_start) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            bit_d   = '0;
            baud_d  = BAUD_LOAD;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            baud_d  = '0;
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign tx        = tx_q;
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLK_DIV=4, DEPTH=4.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
  localparam int DATA_W  = 8;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        tx;
  logic        busy;
  uart_state_e fsm_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] exp_q[$];

  uart_tx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) wr_if ();

  uart_tx_fifo #(
    .CLK_DIV (CLK_DIV),
    .DEPTH   (DEPTH),
    .DATA_W  (DATA_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wr        (wr_if),
    .tx        (tx),
    .busy      (busy),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: byte is presented for exactly one posedge
  task automatic write_byte(input logic [7:0] b);
    wr_if.wr_en   = 1'b1;
    wr_if.wr_data = b;
    @(posedge clk);
    #1;
    wr_if.wr_en = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int exp_level);
    @(negedge clk);
    check({tag, "_tx"}, 32'(tx), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_level"}, 32'(wr_if.level), 32'(exp_level));
  endtask

  // Next negedge must be the first cycle of the start bit.
  task automatic check_frame(input int drop_at, input int exp_lvl0);
    logic [7:0] b;
    logic       exp_bit;
    int         slot;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_queue: got empty expected byte at %0t", $time);
      return;
    end
    b = exp_q.pop_front();
    for (int k = 0; k < 10 * CLK_DIV; k++) begin
      @(negedge clk);
      slot = k / CLK_DIV;
      if (slot == 0)      exp_bit = 1'b0;
      else if (slot <= 8) exp_bit = b[slot-1];
      else                exp_bit = 1'b1;
      check($sformatf("frame_%02h_tx", b), 32'(tx), 32'(exp_bit));
      check($sformatf("frame_%02h_busy", b), 32'(busy), 32'd1);
      if (k == 0 && exp_lvl0 >= 0) check("frame_level0", 32'(wr_if.level), 32'(exp_lvl0));
      if (k == drop_at) ena = 1'b0;
    end
  endtask

  initial begin
    logic [7:0] ov_vals[5];
    ov_vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    rst_n         = 1'b0;
    ena           = 1'b1;
    wr_if.wr_en   = 1'b0;
    wr_if.wr_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset then idle
    check("reset_state", 32'(fsm_state), 32'(IDLE));
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_empty", 32'(wr_if.empty), 32'd1);
      check("idle_full", 32'(wr_if.full), 32'd0);
      check("idle_level", 32'(wr_if.level), 32'd0);
      check("idle_overflow", 32'(wr_if.overflow), 32'd0);
    end

    // single byte 0xA5
    write_byte(8'hA5);
    @(negedge clk);
    check("single_pre_level", 32'(wr_if.level), 32'd1);
    check("single_pre_tx", 32'(tx), 32'd1);
    exp_q.push_back(8'hA5);
    check_frame(-1, 0);
    check_idle("single_post", 0);

    // back-to-back 0x00, 0xFF: second start directly after first stop
    write_byte(8'h00);
    write_byte(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    check_frame(-1, 1);
    check_frame(-1, 0);
    check_idle("b2b_post", 0);

    // overflow with ena low
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      write_byte(ov_vals[i]);
      @(negedge clk);
      check("ovf_level", 32'(wr_if.level), (i >= 3) ? 32'd4 : 32'(i + 1));
      check("ovf_full", 32'(wr_if.full), (i >= 3) ? 32'd1 : 32'd0);
      check("ovf_flag", 32'(wr_if.overflow), (i >= 4) ? 32'd1 : 32'd0);
      check("ovf_tx", 32'(tx), 32'd1);
      check("ovf_busy", 32'(busy), 32'd0);
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(ov_vals[i]);
    ena = 1'b1;
    check_frame(-1, 3);
    check_frame(-1, 2);
    check_frame(-1, 1);
    check_frame(-1, 0);
    check_idle("ovf_post", 0);
    check("ovf_sticky", 32'(wr_if.overflow), 32'd1);
    check("ovf_empty", 32'(wr_if.empty), 32'd1);

    // ena dropped during data bit 3; queued byte waits
    write_byte(8'h5A);
    write_byte(8'hC3);
    exp_q.push_back(8'h5A);
    check_frame(17, 1);
    for (int i = 0; i < 20; i++) check_idle("ena_hold", 1);
    check("ena_hold_state", 32'(fsm_state), 32'(IDLE));
    ena = 1'b1;
    exp_q.push_back(8'hC3);
    check_frame(-1, 0);
    check_idle("ena_post", 0);

    // reset in the middle of DATA
    write_byte(8'h96);
    write_byte(8'h77);
    repeat (20) @(negedge clk);
    check("rst_mid_busy", 32'(busy), 32'd1);
    check("rst_mid_state", 32'(fsm_state), 32'(DATA));
    check("rst_mid_level", 32'(wr_if.level), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_abort_tx", 32'(tx), 32'd1);
    check("rst_abort_busy", 32'(busy), 32'd0);
    check("rst_abort_level", 32'(wr_if.level), 32'd0);
    check("rst_abort_empty", 32'(wr_if.empty), 32'd1);
    check("rst_abort_overflow", 32'(wr_if.overflow), 32'd0);
    rst_n = 1'b1;
    check_idle("rst_quiet", 0);
    write_byte(8'h3C);
    @(negedge clk);
    check("rst_pre_level", 32'(wr_if.level), 32'd1);
    exp_q.push_back(8'h3C);
    check_frame(-1, 0);
    check_idle("rst_post", 0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
